// File: rtl/lcd_cmd_driver_pkg.sv
// Shared types and constants for the HD44780 command driver.
// Holds the LCD command codes, the FSM state enum and the power-up init ROM.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_8B_2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_ENTRY_INC  = 8'h06;

  localparam int unsigned INIT_DEPTH = 5;
  localparam int unsigned INIT_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT_LOAD,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Function set is sent twice; the clear sits fourth so it gets the long wait
  function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
    case (idx)
      3'd0:    return LCD_FUNC_8B_2L;
      3'd1:    return LCD_FUNC_8B_2L;
      3'd2:    return LCD_DISP_ON;
      3'd3:    return LCD_CLEAR;
      3'd4:    return LCD_ENTRY_INC;
      default: return LCD_FUNC_8B_2L;
    endcase
  endfunction

endpackage

// File: rtl/lcd_cmd_driver_if.sv
// Upstream byte handshake between the text logic and the LCD driver.
interface lcd_cmd_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;

  modport master (output in_valid, output in_rs, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_delay_counter.sv
// Shared down-counter: load N-1 on state entry, done flags a count of zero.
module lcd_delay_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  // done is kept as a register mirroring (cnt_q == 0)
  always_ff @(posedge clk) begin
    if (load) begin
      cnt_q <= load_val;
      done  <= (load_val == '0);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
      done  <= (cnt_q == W'(1));
    end
  end

endmodule

// File: rtl/lcd_cmd_driver.sv
// HD44780 write-only bus driver: runs the power-up init sequence, then
// writes one upstream byte at a time with setup / enable / hold / wait timing.
module lcd_cmd_driver
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 75000,
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned EN_HIGH_CYC    = 3,
  parameter int unsigned HOLD_CYC       = 1,
  parameter int unsigned CMD_WAIT_CYC   = 200,
  parameter int unsigned CLEAR_WAIT_CYC = 7600
) (
  input  logic              clk,
  input  logic              reset,
  lcd_cmd_driver_if.slave   bus,
  output logic              init_done,
  output logic              en,
  output logic [7:0]        lcd_data,
  output logic              rs,
  output logic              rw,
  output logic              on
);

  localparam int unsigned MAX_CYC = max_u(max_u(max_u(POWERUP_CYC, SETUP_CYC),
                                                max_u(EN_HIGH_CYC, HOLD_CYC)),
                                          max_u(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
  localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;

  lcd_state_e            state_q, state_d;
  logic [INIT_IDX_W-1:0] idx_q, idx_d;
  logic                  init_done_d;
  logic [7:0]            data_d;
  logic                  rs_d;
  logic                  in_ready_q;
  logic                  cnt_load_c;
  logic [CNT_W-1:0]      cnt_val_c;
  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_load_val;
  logic                  cnt_done;
  logic                  long_wait_c;

  assign rw           = 1'b0;
  assign bus.in_ready = in_ready_q;

  // Reset reloads the counter with the power-up delay
  assign cnt_load     = reset | cnt_load_c;
  assign cnt_load_val = reset ? CNT_W'(POWERUP_CYC - 1) : cnt_val_c;

  assign long_wait_c = !rs && (lcd_data inside {8'h01, 8'h02, 8'h03});

  lcd_delay_counter #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_POWERUP;
      idx_q      <= '0;
      init_done  <= 1'b0;
      en         <= 1'b0;
      lcd_data   <= 8'h00;
      rs         <= 1'b0;
      on         <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      init_done  <= init_done_d;
      en         <= (state_d == ST_PULSE);
      lcd_data   <= data_d;
      rs         <= rs_d;
      on         <= 1'b1;
      in_ready_q <= (state_d == ST_IDLE);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done;
    data_d      = lcd_data;
    rs_d        = rs;
    cnt_load_c  = 1'b0;
    cnt_val_c   = '0;

    case (state_q)
      ST_POWERUP: begin
        if (cnt_done) state_d = ST_INIT_LOAD;
      end
      ST_INIT_LOAD: begin
        data_d     = init_rom(idx_q);
        rs_d       = 1'b0;
        idx_d      = idx_q + INIT_IDX_W'(1);
        state_d    = ST_SETUP;
        cnt_load_c = 1'b1;
        cnt_val_c  = CNT_W'(SETUP_CYC - 1);
      end
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          data_d     = bus.in_data;
          rs_d       = bus.in_rs;
          state_d    = ST_SETUP;
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_d    = ST_PULSE;
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(EN_HIGH_CYC - 1);
        end
      end
      ST_PULSE: begin
        if (cnt_done) begin
          state_d    = ST_HOLD;
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(HOLD_CYC - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_d    = ST_WAIT;
          cnt_load_c = 1'b1;
          cnt_val_c  = long_wait_c ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_done) begin
          if (init_done) begin
            state_d = ST_IDLE;
          end else if (idx_q == INIT_IDX_W'(INIT_DEPTH)) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d = ST_INIT_LOAD;
          end
        end
      end
      default: state_d = ST_POWERUP;
    endcase
  end

endmodule
